knn_sequencer: RTL and testbench
================================

KNN_SEQUENCER -- requirements
Module: knn_sequencer

Interface
REQ-001 Parameter N_SAMPLES, default 128: number of stored samples scanned in the distance phase.
REQ-002 Parameter K, default 5: number of nearest neighbours tallied in the count phase.
REQ-003 Parameter N_LABELS, default 4: number of label bins examined in the vote phase.
REQ-004 Parameter ADDR_W, default 7: address width, which SHALL satisfy 2**ADDR_W >= max(N_SAMPLES, K, N_LABELS).
REQ-005 clk  in  1  sole clock, rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request a classification; sampled only in IDLE.
REQ-008 abort  in  1  cancel an in-progress classification.
REQ-009 unknown_in  in  8  query sample, captured on accepted start.
REQ-010 query  out  8  latched query, held stable for the whole run.
REQ-011 address  out  ADDR_W  phase-local index to the datapath.
REQ-012 state  out  2  datapath phase: 00 idle/clear/done, 01 distance, 10 count, 11 vote.
REQ-013 clear  out  1  one-cycle pulse that resets the datapath top-K registers and label counters.
REQ-014 busy  out  1  high in every FSM state except IDLE.
REQ-015 done  out  1  one-cycle pulse: the result label in the datapath is valid.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, DIST, COUNT, VOTE and DONE.
REQ-017 IDLE->CLEAR on a clock edge where start=1 and abort=0; on that same edge query SHALL load unknown_in.
REQ-018 CLEAR SHALL last 1 cycle with clear=1 and state=00, then go to DIST.
REQ-019 DIST SHALL last N_SAMPLES cycles with state=01 and address 0..N_SAMPLES-1, incrementing by 1 per cycle.
REQ-020 COUNT SHALL last K cycles with state=10 and address 0..K-1.
REQ-021 VOTE SHALL last N_LABELS cycles with state=11 and address 0..N_LABELS-1.
REQ-022 DONE SHALL last 1 cycle with done=1 and state=00, then return to IDLE.
REQ-023 address SHALL restart at 0 on every phase entry and SHALL be 0 in IDLE, CLEAR and DONE; it SHALL never exceed the phase's terminal count.
REQ-024 The done pulse SHALL begin 1+N_SAMPLES+K+N_LABELS clock edges (138 at defaults) after the edge that accepted start.
REQ-025 A start asserted while busy=1 SHALL be ignored and SHALL NOT alter query.
REQ-026 abort=1 in any state other than IDLE SHALL force IDLE on the next edge with no done pulse; abort SHALL take priority over start and over phase advance.
REQ-027 A start held continuously high SHALL launch back-to-back runs, each separated by exactly one IDLE cycle.

Reset
REQ-028 On rst=1 at a clock edge the FSM SHALL enter IDLE, with address=0, state=00, query=0, clear=0, busy=0 and done=0.
REQ-029 rst SHALL override start and abort, including a reset asserted mid-run.

Configuration
REQ-030 With KNN_SEQ_PERF_EN defined, the block SHALL add an output run_count [15:0] that increments on each DONE cycle, saturates at 16'hFFFF, is unchanged by abort and clears on rst.
REQ-031 Without KNN_SEQ_PERF_EN, run_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package knn_pkg SHALL hold the phase encoding constants PH_IDLE/PH_DIST/PH_COUNT/PH_VOTE, the FSM state typedef, and the default values of N_SAMPLES, K and N_LABELS.
REQ-033 Sub-module knn_addr_counter SHALL provide the loadable, clearable phase address counter and its terminal-count flag, compared against the active phase length.

Verification
REQ-034 Start with unknown_in=8'hA5 -> clear pulse 1 cycle later; state=01 for 128 cycles with address 0..127; state=10 for 5 cycles with address 0..4; state=11 for 4 cycles with address 0..3; done 138 edges after start; query=8'hA5 throughout.
REQ-035 Abort at DIST address 60 -> IDLE next cycle, address=0, busy=0, no done, and run_count unchanged under KNN_SEQ_PERF_EN.
REQ-036 Start pulse at DIST address 10 with unknown_in=8'h3C -> ignored, query keeps its first value, and done timing is unchanged.
REQ-037 rst asserted during VOTE -> IDLE with all outputs 0 next cycle; a subsequent start runs a full 138-edge sequence.
REQ-038 start held high for 3 runs -> 3 done pulses spaced 140 cycles apart, and run_count=3 under KNN_SEQ_PERF_EN.
REQ-039 start=1 and abort=1 together in IDLE -> no run begins, busy stays 0, and query is unchanged.

Source files
------------

// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : knn_pkg
//  Description : Shared constants and types for the k-NN classification
//                sequencer: datapath phase encoding, FSM state type and
//                default scan lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
package knn_pkg;

    // Phase code presented to the datapath on the 'state' output
    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_DIST  = 2'b01;
    localparam logic [1:0] PH_COUNT = 2'b10;
    localparam logic [1:0] PH_VOTE  = 2'b11;

    // Default scan lengths
    localparam int DEF_N_SAMPLES = 128;
    localparam int DEF_K         = 5;
    localparam int DEF_N_LABELS  = 4;
    localparam int DEF_ADDR_W    = 7;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_DIST  = 3'd2,
        S_COUNT = 3'd3,
        S_VOTE  = 3'd4,
        S_DONE  = 3'd5
    } knn_state_t;

endpackage : knn_pkg
`default_nettype wire

// File: rtl/knn_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : knn_addr_counter
//  Description : Loadable, clearable phase address counter. tc is raised
//                while the count equals 'last', the final index of the
//                active phase (phase length minus one).
//  Revision    : 1.0 - initial release
// ============================================================================
module knn_addr_counter #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              en,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    // Load has priority over increment so a phase boundary restarts at once
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= count + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Terminal count of the active phase
    assign tc = (count == last);

endmodule : knn_addr_counter
`default_nettype wire

// File: rtl/knn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : knn_sequencer
//  Description : Control sequencer for a k-NN classifier datapath. A run
//                walks CLEAR -> DIST -> COUNT -> VOTE -> DONE, driving a
//                phase-local address and phase code to the datapath.
//                Optional feature macro: KNN_SEQ_PERF_EN adds a saturating
//                completed-run counter output (run_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module knn_sequencer
    import knn_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int K         = DEF_K,
    parameter int N_LABELS  = DEF_N_LABELS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        unknown_in,
    output logic [7:0]        query,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        state,
    output logic              clear,
    output logic              busy,
`ifdef KNN_SEQ_PERF_EN
    output logic [15:0]       run_count,
`endif
    output logic              done
);

    // Final index of each scanning phase
    localparam logic [ADDR_W-1:0] DIST_LAST  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] COUNT_LAST = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] VOTE_LAST  = ADDR_W'(N_LABELS - 1);

    knn_state_t        r_state;
    knn_state_t        w_next;
    logic [7:0]        r_query;
    logic [ADDR_W-1:0] w_last;
    logic              w_tc;
    logic              w_counting;
    logic              w_accept;
    logic              w_load;

    assign w_counting = (r_state == S_DIST) || (r_state == S_COUNT) || (r_state == S_VOTE);
    assign w_accept   = (r_state == S_IDLE) && start && !abort;

    // Address restarts at zero outside scanning phases, at each phase
    // boundary and on abort, so every phase entry sees address 0
    assign w_load = !w_counting || w_tc || abort;

    // Select the terminal index for the phase currently scanning
    always_comb begin
        w_last = DIST_LAST;
        case (r_state)
            S_COUNT: w_last = COUNT_LAST;
            S_VOTE:  w_last = VOTE_LAST;
            default: w_last = DIST_LAST;
        endcase
    end

    knn_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_value ({ADDR_W{1'b0}}),
        .en         (w_counting),
        .last       (w_last),
        .count      (address),
        .tc         (w_tc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and phase outputs; abort overrides any phase advance
    always_comb begin
        w_next = r_state;
        state  = PH_IDLE;
        clear  = 1'b0;
        done   = 1'b0;
        busy   = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                clear  = 1'b1;
                w_next = S_DIST;
            end
            S_DIST: begin
                state = PH_DIST;
                if (w_tc) w_next = S_COUNT;
            end
            S_COUNT: begin
                state = PH_COUNT;
                if (w_tc) w_next = S_VOTE;
            end
            S_VOTE: begin
                state = PH_VOTE;
                if (w_tc) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    // Query is captured only when a run is accepted and held for its duration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_query <= 8'h00;
        end else if (w_accept) begin
            r_query <= unknown_in;
        end
    end

    assign query = r_query;

`ifdef KNN_SEQ_PERF_EN
    logic [15:0] r_run_count;

    // Count completed runs, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_count <= 16'h0000;
        end else if ((r_state == S_DONE) && (r_run_count != 16'hFFFF)) begin
            r_run_count <= r_run_count + 16'd1;
        end
    end

    assign run_count = r_run_count;
`endif

endmodule : knn_sequencer
`default_nettype wire

// File: tb/tb_knn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_knn_sequencer
//  Description : Self-checking bench for knn_sequencer. A run-level model
//                tracks accepted runs and derives every output from the
//                number of edges elapsed since acceptance; completion events
//                are queued and matched against the DUT done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_sequencer;

    localparam int NS   = 128;
    localparam int KK   = 5;
    localparam int NL   = 4;
    localparam int AW   = 7;
    localparam int RUNL = 1 + NS + KK + NL;   // edges from accept to done

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [7:0]    unknown_in;
    logic [7:0]    query;
    logic [AW-1:0] address;
    logic [1:0]    state;
    logic          clear;
    logic          busy;
    logic          done;
`ifdef KNN_SEQ_PERF_EN
    logic [15:0]   run_count;
`endif

    knn_sequencer #(
        .N_SAMPLES (NS),
        .K         (KK),
        .N_LABELS  (NL),
        .ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .unknown_in (unknown_in),
        .query      (query),
        .address    (address),
        .state      (state),
        .clear      (clear),
        .busy       (busy),
`ifdef KNN_SEQ_PERF_EN
        .run_count  (run_count),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    // Checking bookkeeping
    int n_checks = 0;
    int n_errors = 0;

    // Run-level reference model
    int         edge_n   = 0;
    bit         m_active = 1'b0;
    int         m_acc    = 0;
    logic [7:0] m_query  = 8'h00;
    int         m_runs   = 0;
    int         exp_edge_q[$];
    logic [7:0] exp_query_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, edge_n);
        end
    endtask

    task automatic cancel_pending();
        if (exp_edge_q.size() > 0 && exp_edge_q[$] >= edge_n) begin
            void'(exp_edge_q.pop_back());
            void'(exp_query_q.pop_back());
        end
    endtask

    // Advance the model by one clock edge using the inputs applied before it
    task automatic model_step();
        edge_n++;
        if (rst) begin
            if (m_active) cancel_pending();
            m_active = 1'b0;
            m_query  = 8'h00;
            m_runs   = 0;
        end else if (m_active) begin
            if (edge_n - m_acc == RUNL + 1) begin
                m_active = 1'b0;
                if (m_runs < 65535) m_runs++;
            end else if (abort) begin
                cancel_pending();
                m_active = 1'b0;
            end
        end else if (start && !abort) begin
            m_active = 1'b1;
            m_acc    = edge_n;
            m_query  = unknown_in;
            exp_edge_q.push_back(edge_n + RUNL);
            exp_query_q.push_back(unknown_in);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: derive expected outputs from elapsed edges and compare
    initial begin
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                int       d;
                int       e_addr;
                int       e_state;
                bit       e_clear;
                bit       e_done;
                bit       e_busy;
                e_addr  = 0;
                e_state = 0;
                e_clear = 1'b0;
                e_done  = 1'b0;
                e_busy  = m_active;
                if (m_active) begin
                    d = edge_n - m_acc;
                    if (d == 0) begin
                        e_clear = 1'b1;
                    end else if (d <= NS) begin
                        e_state = 1; e_addr = d - 1;
                    end else if (d <= NS + KK) begin
                        e_state = 2; e_addr = d - 1 - NS;
                    end else if (d <= NS + KK + NL) begin
                        e_state = 3; e_addr = d - 1 - NS - KK;
                    end else begin
                        e_done = 1'b1;
                    end
                end
                check("state",   32'(state),   32'(e_state));
                check("address", 32'(address), 32'(e_addr));
                check("clear",   32'(clear),   32'(e_clear));
                check("busy",    32'(busy),    32'(e_busy));
                check("done",    32'(done),    32'(e_done));
                check("query",   32'(query),   32'(m_query));
`ifdef KNN_SEQ_PERF_EN
                check("run_count", 32'(run_count), 32'(m_runs));
`endif
                if (done === 1'b1) begin
                    if (exp_edge_q.size() == 0) begin
                        check("done_unexpected", 32'(1), 32'(0));
                    end else begin
                        check("done_edge",  32'(edge_n), 32'(exp_edge_q.pop_front()));
                        check("done_query", 32'(query),  32'(exp_query_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one edge; on return the accepting edge has just passed
    task automatic run_start(input logic [7:0] v);
        unknown_in = v;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Stimulus
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        unknown_in = 8'h00;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);

        // Full run
        run_start(8'hA5);
        wait_cycles(RUNL + 6);

        // Abort at DIST address 60
        run_start(8'h11);
        wait_cycles(61);
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        wait_cycles(5);

        // Start pulse during DIST address 10 must be ignored
        run_start(8'h5A);
        wait_cycles(11);
        unknown_in = 8'h3C;
        start      = 1'b1;
        wait_cycles(1);
        start      = 1'b0;
        wait_cycles(RUNL);

        // Reset during VOTE, then a full run
        run_start(8'h77);
        wait_cycles(NS + KK + 2);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(3);
        run_start(8'hC3);
        wait_cycles(RUNL + 6);

        // start held high: three back-to-back runs
        unknown_in = 8'h99;
        start      = 1'b1;
        wait_cycles(2 * (RUNL + 2) + 2);
        start      = 1'b0;
        wait_cycles(RUNL + 10);

        // start together with abort in IDLE
        unknown_in = 8'hEE;
        start      = 1'b1;
        abort      = 1'b1;
        wait_cycles(1);
        start      = 1'b0;
        abort      = 1'b0;
        wait_cycles(3);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 5) == 0);
            abort      = ($urandom_range(0, 199) == 0);
            unknown_in = 8'($urandom);
            wait_cycles(1);
        end
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wait_cycles(RUNL + 10);

        check("pending_done", 32'(exp_edge_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_knn_sequencer
`default_nettype wire
